// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive stimulus engine: sweeps every input vector to a combinational DUT,
// compacts the sampled responses into a MISR signature and checks it against a golden value.
module exhaustive_sweep_checker #(
  parameter int              N_IN  = 4,
  parameter int              N_OUT = 2,
  parameter int              HOLD  = 20,
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [N_IN:0]    vec_count
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [HC_W-1:0]  hold_cnt;
  logic [SIG_W-1:0] sig_next;
  logic             capture;
  logic             last_vec;

  // MISR step: shift left, fold the outgoing MSB back through POLY, inject the response.
  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(dut_out);
    capture  = (hold_cnt == HOLD_LAST);
    last_vec = (dut_in == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dut_in    <= '0;
      signature <= '0;
      vec_count <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_APPLY;
            dut_in    <= '0;
            hold_cnt  <= '0;
            signature <= '0;
            vec_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_APPLY: begin
          if (!capture) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            signature <= sig_next;
            vec_count <= vec_count + 1'b1;
            hold_cnt  <= '0;
            if (!last_vec) begin
              dut_in <= dut_in + 1'b1;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden_sig);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
